// File: rtl/alu_issue_pipe_if.sv
// Handshake bundle between the command producer, alu_issue_pipe and the result consumer.
interface alu_issue_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_acc;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_neg;
  logic             out_pos;
  logic             out_zero;
  logic [CW-1:0]    fifo_count;

  modport master (
    output in_valid, in_op, in_acc, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_neg, out_pos, out_zero, fifo_count
  );

  modport slave (
    input  in_valid, in_op, in_acc, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_neg, out_pos, out_zero, fifo_count
  );
endinterface

// File: rtl/alu_issue_pipe.sv
// Command FIFO feeding a combinational ALU whose result/flags land in a valid/ready output register.
// Optional accumulator operand enabled by defining ALU_ISSUE_ACC_EN.
module alu_issue_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_pipe_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [1:0]       op;
`ifdef ALU_ISSUE_ACC_EN
    logic             acc;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wdata;
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             fire;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_pos;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             neg_q;
  logic             pos_q;
  logic             zero_q;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign fire  = !empty && (!valid_q || bus.out_ready);
  assign head  = mem[rd_ptr];

  always_comb begin
    wdata    = '0;
    wdata.op = bus.in_op;
`ifdef ALU_ISSUE_ACC_EN
    wdata.acc = bus.in_acc;
`endif
    wdata.a  = bus.in_a;
    wdata.b  = bus.in_b;
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ALU_ISSUE_ACC_EN
  logic [WIDTH-1:0] acc_q;

  // Accumulator follows every issued result so chained accumulate commands see the newest value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (fire) begin
      acc_q <= alu_res;
    end
  end

  assign opa = head.acc ? acc_q : head.a;
`else
  logic unused_in_acc;
  assign unused_in_acc = bus.in_acc;
  assign opa = head.a;
`endif

  always_comb begin
    alu_res = '0;
    case (head.op)
      2'b00:   alu_res = opa + head.b;
      2'b01:   alu_res = opa - head.b;
      2'b10:   alu_res = opa & head.b;
      default: alu_res = opa | head.b;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign alu_neg  = alu_res[WIDTH-1] && !alu_zero;
  assign alu_pos  = !alu_neg && !alu_zero;

  // Output register: load on issue, otherwise clear valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      pos_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else if (fire) begin
      valid_q  <= 1'b1;
      result_q <= alu_res;
      neg_q    <= alu_neg;
      pos_q    <= alu_pos;
      zero_q   <= alu_zero;
    end else if (valid_q && bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_neg    = neg_q;
  assign bus.out_pos    = pos_q;
  assign bus.out_zero   = zero_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_alu_issue_pipe.sv
// Self-checking bench for alu_issue_pipe: directed scenarios plus randomized traffic against a result scoreboard.
module tb_alu_issue_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
  alu_issue_pipe #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int accepted = 0;
  logic [W+2:0] expq[$];
  logic [W+2:0] obsq[$];
  logic [W-1:0] macc = '0;

  // Expected {neg,pos,zero,result} straight from the operation definitions.
  function automatic logic [W+2:0] ref_out(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic n, p, z;
    case (op)
      2'd0:    r = W'((int'(a) + int'(b)) % (1 << W));
      2'd1:    r = W'((int'(a) - int'(b) + (1 << W)) % (1 << W));
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    z = (int'(r) == 0);
    n = (int'(r) >= (1 << (W - 1)));
    p = !n && !z;
    return {n, p, z, r};
  endfunction

  // One clock: apply inputs, log accepted commands and consumed results, advance past the edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic acc,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
    logic [W-1:0] opa;
    logic [W+2:0] e;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_acc    = acc;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    #1;
    if (v && bus.in_ready) begin
`ifdef ALU_ISSUE_ACC_EN
      opa = acc ? macc : a;
`else
      opa = a;
`endif
      e = ref_out(op, opa, b);
      macc = e[W-1:0];
      expq.push_back(e);
      accepted++;
    end
    if (bus.out_valid && ordy) begin
      obsq.push_back({bus.out_neg, bus.out_pos, bus.out_zero, bus.out_result});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 2'd0, 1'b0, '0, '0, ordy);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    expq.delete();
    obsq.delete();
    macc = '0;
    accepted = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op = 2'd0; bus.in_acc = 1'b0; bus.in_a = 8'h11; bus.in_b = 8'h22;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++; if (bus.fifo_count !== CW'(0)) begin fails++; $display("FAIL reset_fifo_count got=%0d exp=0", bus.fifo_count); end
    tests++; if ({bus.out_neg, bus.out_pos, bus.out_zero} !== 3'b001) begin
      fails++; $display("FAIL reset_flags got=%b exp=001", {bus.out_neg, bus.out_pos, bus.out_zero}); end
    tests++; if (bus.out_result !== '0) begin fails++; $display("FAIL reset_result got=%h exp=00", bus.out_result); end
    do_reset(1);
  endtask

  task automatic test_ops();
    logic [1:0]   ops  [4];
    logic [W-1:0] as   [4];
    logic [W-1:0] bs   [4];
    logic [W+2:0] want [4];
    logic [W+2:0] got;
    do_reset(1);
    ops[0] = 2'd0; as[0] = 8'h05; bs[0] = 8'h03; want[0] = {3'b010, 8'h08};
    ops[1] = 2'd1; as[1] = 8'h03; bs[1] = 8'h05; want[1] = {3'b100, 8'hFE};
    ops[2] = 2'd2; as[2] = 8'hF0; bs[2] = 8'h0F; want[2] = {3'b001, 8'h00};
    ops[3] = 2'd3; as[3] = 8'hA0; bs[3] = 8'h05; want[3] = {3'b100, 8'hA5};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, ops[k], 1'b0, as[k], bs[k], 1'b1);
      else idle(1'b1);
      got = {bus.out_neg, bus.out_pos, bus.out_zero, bus.out_result};
      if (k == 0 || k == 5) begin
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ops_valid_c%0d got=%b exp=0", k, bus.out_valid); end
      end else begin
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL ops_valid_c%0d got=%b exp=1", k, bus.out_valid); end
        tests++; if (got !== want[k-1]) begin fails++; $display("FAIL ops_result_%0d got=%h exp=%h", k - 1, got, want[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 2'($urandom_range(3)), 1'b0, W'($urandom), W'($urandom), 1'b0);
    end
    tests++; if (accepted != 5) begin fails++; $display("FAIL bp_accepted got=%0d exp=5", accepted); end
    tests++; if (bus.fifo_count !== CW'(D)) begin fails++; $display("FAIL bp_fifo_count got=%0d exp=%0d", bus.fifo_count, D); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
    for (int k = 0; k < 20 && obsq.size() < 5; k++) idle(1'b1);
    repeat (3) idle(1'b1);
    tests++; if (obsq.size() != 5) begin fails++; $display("FAIL bp_result_count got=%0d exp=5", obsq.size()); end
    for (int i = 0; i < 5 && i < obsq.size(); i++) begin
      tests++; if (obsq[i] !== expq[i]) begin fails++; $display("FAIL bp_result_%0d got=%h exp=%h", i, obsq[i], expq[i]); end
    end
  endtask

  task automatic test_wrap();
    int unsigned n = 3 * D + 1;
    logic ordy, v, hold;
    logic [W+2:0] snap;
    do_reset(1);
    for (int cyc = 0; cyc < 400 && !(accepted == n && obsq.size() == n); cyc++) begin
      v = (accepted < n) && ($urandom_range(3) != 0);
      ordy = 1'($urandom_range(1));
      hold = bus.out_valid && !ordy;
      snap = {bus.out_neg, bus.out_pos, bus.out_zero, bus.out_result};
      drive(v, 2'($urandom_range(3)), 1'($urandom_range(1)), W'($urandom), W'($urandom), ordy);
      tests++; if (bus.fifo_count > CW'(D)) begin fails++; $display("FAIL wrap_count_bound got=%0d max=%0d", bus.fifo_count, D); end
      tests++; if (bus.in_ready !== (bus.fifo_count != CW'(D))) begin
        fails++; $display("FAIL wrap_in_ready got=%b count=%0d", bus.in_ready, bus.fifo_count); end
      if (hold) begin
        tests++; if (bus.out_valid !== 1'b1 || {bus.out_neg, bus.out_pos, bus.out_zero, bus.out_result} !== snap) begin
          fails++; $display("FAIL wrap_hold got=%h exp=%h", {bus.out_neg, bus.out_pos, bus.out_zero, bus.out_result}, snap); end
      end
    end
    tests++; if (obsq.size() != n) begin fails++; $display("FAIL wrap_result_count got=%0d exp=%0d", obsq.size(), n); end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      tests++; if (obsq[i] !== expq[i]) begin fails++; $display("FAIL wrap_result_%0d got=%h exp=%h", i, obsq[i], expq[i]); end
    end
  endtask

  task automatic test_accumulate();
    logic [W+2:0] want [3];
`ifdef ALU_ISSUE_ACC_EN
    want[0] = {3'b010, 8'h01}; want[1] = {3'b010, 8'h02}; want[2] = {3'b010, 8'h03};
`else
    want[0] = {3'b010, 8'h01}; want[1] = {3'b010, 8'h01}; want[2] = {3'b010, 8'h01};
`endif
    do_reset(1);
    for (int k = 0; k < 3; k++) drive(1'b1, 2'd0, 1'b1, 8'h00, 8'h01, 1'b1);
    for (int k = 0; k < 10 && obsq.size() < 3; k++) idle(1'b1);
    tests++; if (obsq.size() != 3) begin fails++; $display("FAIL acc_result_count got=%0d exp=3", obsq.size()); end
    for (int i = 0; i < 3 && i < obsq.size(); i++) begin
      tests++; if (obsq[i] !== want[i]) begin fails++; $display("FAIL acc_result_%0d got=%h exp=%h", i, obsq[i], want[i]); end
    end
  endtask

  task automatic test_midstream_reset();
    logic [W+2:0] want;
    do_reset(1);
    for (int k = 0; k < 4; k++) drive(1'b1, 2'($urandom_range(3)), 1'b0, W'($urandom), W'($urandom), 1'b0);
    tests++; if (bus.fifo_count !== CW'(3)) begin fails++; $display("FAIL mid_pre_count got=%0d exp=3", bus.fifo_count); end
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got=%b exp=1", bus.out_valid); end
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++; if (bus.fifo_count !== CW'(0)) begin fails++; $display("FAIL mid_count got=%0d exp=0", bus.fifo_count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
    rst_n = 1'b1;
    expq.delete(); obsq.delete(); macc = '0; accepted = 0;
    drive(1'b1, 2'd1, 1'b0, 8'h40, 8'h50, 1'b1);
    want = {3'b100, 8'hF0};
    repeat (6) idle(1'b1);
    tests++; if (obsq.size() != 1) begin fails++; $display("FAIL mid_result_count got=%0d exp=1", obsq.size()); end
    if (obsq.size() > 0) begin
      tests++; if (obsq[0] !== want) begin fails++; $display("FAIL mid_result got=%h exp=%h", obsq[0], want); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_acc = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    test_reset();
    test_ops();
    test_backpressure();
    test_wrap();
    test_accumulate();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
